// File: rtl/pipe_share_sched.sv
// pipe_share_sched: shares one fixed-latency, go-triggered pipelined unit
// between two requesters. Round-robin grant, initiation-interval cooldown,
// and a tag pipeline that routes each result back to the requester that
// issued it as a registered one-cycle pulse.
//
// Handshake: a requester raises reqN_valid with operands on reqN_l/reqN_r.
// reqN_ready is a same-cycle combinational grant that is only ever high
// while reqN_valid is high; the transfer (and the unit issue) happens in
// any cycle with valid && ready. Valid must not depend on ready. Operands
// only need to be stable in the transfer cycle. Responses have no
// backpressure.
module pipe_share_sched #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,   // go cycle -> unit_out valid cycle, >= 1
    parameter int II      = 2    // min cycles between go pulses, >= 1
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_l,
    input  logic [WIDTH-1:0] req0_r,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_l,
    input  logic [WIDTH-1:0] req1_r,
    output logic             unit_go,
    output logic [WIDTH-1:0] unit_l,
    output logic [WIDTH-1:0] unit_r,
    input  logic [WIDTH-1:0] unit_out,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_data,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_data,
    output logic             busy
);

    // Cooldown counter only has to hold II-1; keep at least one bit so the
    // II==1 case (always zero) still elaborates cleanly.
    localparam int              CW      = (II > 1) ? $clog2(II) : 1;
    localparam logic [CW-1:0]   CD_LOAD = CW'(II - 1);

    logic [CW-1:0]      cooldown;
    logic               ptr;        // 0: prefer requester 0, 1: prefer requester 1
    logic [LATENCY-1:0] tag_v;      // per-stage "an issue is in flight here"
    logic [LATENCY-1:0] tag_id;     // per-stage requester id of that issue

    logic can_issue;
    logic pick1;
    logic grant0;
    logic grant1;
    logic issue;
    logic gid;
    logic fin_v;
    logic fin_id;

    // Grant: one requester per permitted cycle, pointer breaks ties.
    always_comb begin
        can_issue = reset && (cooldown == '0);
        pick1     = req1_valid && (!req0_valid || ptr);
        grant0    = can_issue && req0_valid && !pick1;
        grant1    = can_issue && pick1;
        issue     = grant0 || grant1;
        gid       = grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign unit_go    = issue;

    // Operand mux: zero whenever nothing is issued so the unit sees no stale data.
    always_comb begin
        unit_l = '0;
        unit_r = '0;
        if (grant0) begin
            unit_l = req0_l;
            unit_r = req0_r;
        end else if (grant1) begin
            unit_l = req1_l;
            unit_r = req1_r;
        end
    end

    // The tag that reaches the last stage lines up with the cycle unit_out is valid.
    assign fin_v  = tag_v[LATENCY-1];
    assign fin_id = tag_id[LATENCY-1];

    // Cooldown and round-robin pointer: load II-1 on issue, count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cooldown <= '0;
            ptr      <= 1'b0;
        end else begin
            if (issue) begin
                cooldown <= CD_LOAD;
                ptr      <= ~gid;
            end else if (cooldown != '0) begin
                cooldown <= cooldown - CW'(1);
            end
        end
    end

    // Tag pipeline: shift every cycle, stage 0 takes this cycle's issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= gid;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Response capture: route unit_out to the issuing requester; data holds between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
        end else begin
            resp0_valid <= fin_v && !fin_id;
            resp1_valid <= fin_v && fin_id;
            if (fin_v && !fin_id) begin
                resp0_data <= unit_out;
            end
            if (fin_v && fin_id) begin
                resp1_data <= unit_out;
            end
        end
    end

    // Busy is derived only from registered state, so it is clean and zero in reset.
    assign busy = (|tag_v) || (cooldown != '0) || resp0_valid || resp1_valid;

endmodule

// File: tb/tb_pipe_share_sched.sv
module tb_pipe_share_sched;
  localparam int W  = 32;
  localparam int LA = 2;
  localparam int IA = 2;
  localparam int LB = 1;
  localparam int IB = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (LATENCY=2, II=2) ----------------
  logic         a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic [W-1:0] a_req0_l, a_req0_r, a_req1_l, a_req1_r;
  logic         a_unit_go;
  logic [W-1:0] a_unit_l, a_unit_r, a_unit_out;
  logic         a_resp0_valid, a_resp1_valid, a_busy;
  logic [W-1:0] a_resp0_data, a_resp1_data;

  pipe_share_sched #(.WIDTH(W), .LATENCY(LA), .II(IA)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_l(a_req0_l), .req0_r(a_req0_r),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_l(a_req1_l), .req1_r(a_req1_r),
    .unit_go(a_unit_go), .unit_l(a_unit_l), .unit_r(a_unit_r), .unit_out(a_unit_out),
    .resp0_valid(a_resp0_valid), .resp0_data(a_resp0_data),
    .resp1_valid(a_resp1_valid), .resp1_data(a_resp1_data),
    .busy(a_busy)
  );

  // ---------------- DUT B (LATENCY=1, II=1) ----------------
  logic         b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [W-1:0] b_req0_l, b_req0_r, b_req1_l, b_req1_r;
  logic         b_unit_go;
  logic [W-1:0] b_unit_l, b_unit_r, b_unit_out;
  logic         b_resp0_valid, b_resp1_valid, b_busy;
  logic [W-1:0] b_resp0_data, b_resp1_data;

  pipe_share_sched #(.WIDTH(W), .LATENCY(LB), .II(IB)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_l(b_req0_l), .req0_r(b_req0_r),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_l(b_req1_l), .req1_r(b_req1_r),
    .unit_go(b_unit_go), .unit_l(b_unit_l), .unit_r(b_unit_r), .unit_out(b_unit_out),
    .resp0_valid(b_resp0_valid), .resp0_data(b_resp0_data),
    .resp1_valid(b_resp1_valid), .resp1_data(b_resp1_data),
    .busy(b_busy)
  );

  // ---------------- pipelined adder models (junk when not valid) ----------------
  logic [W:0] ua_pipe [LA];
  logic [W:0] ub_pipe [LB];
  always @(posedge clk) begin
    ua_pipe[0] <= {a_unit_go, a_unit_l + a_unit_r};
    for (int i = 1; i < LA; i++) ua_pipe[i] <= ua_pipe[i-1];
    ub_pipe[0] <= {b_unit_go, b_unit_l + b_unit_r};
    for (int i = 1; i < LB; i++) ub_pipe[i] <= ub_pipe[i-1];
  end
  assign a_unit_out = (ua_pipe[LA-1][W] === 1'b1) ? ua_pipe[LA-1][W-1:0] : (32'hBAD0_0000 ^ W'(cyc));
  assign b_unit_out = (ub_pipe[LB-1][W] === 1'b1) ? ub_pipe[LB-1][W-1:0] : (32'hBAD1_0000 ^ W'(cyc));

  // ---------------- stimulus queues and scoreboard ----------------
  logic [2*W-1:0] a0_q[$], a1_q[$], b0_q[$], b1_q[$];  // {l, r}
  logic [W-1:0]   exp_a_q[$], exp_b_q[$];
  logic           exp_a_id_q[$], exp_b_id_q[$];
  int             exp_a_cyc_q[$], exp_b_cyc_q[$];
  logic           grant_log_a[$];
  int n_checks = 0;
  int n_fail   = 0;

  // One clock cycle: drive at posedge+1, sample/score at negedge.
  task automatic step(input logic rst_val);
    logic [W-1:0] d;
    logic         id;
    int           due;
    @(posedge clk); #1;
    reset = rst_val;
    if (rst_val == 1'b0) begin
      exp_a_q.delete(); exp_a_id_q.delete(); exp_a_cyc_q.delete();
      exp_b_q.delete(); exp_b_id_q.delete(); exp_b_cyc_q.delete();
    end
    a_req0_valid = (a0_q.size() > 0);
    if (a_req0_valid) {a_req0_l, a_req0_r} = a0_q[0]; else begin a_req0_l = $urandom; a_req0_r = $urandom; end
    a_req1_valid = (a1_q.size() > 0);
    if (a_req1_valid) {a_req1_l, a_req1_r} = a1_q[0]; else begin a_req1_l = $urandom; a_req1_r = $urandom; end
    b_req0_valid = (b0_q.size() > 0);
    if (b_req0_valid) {b_req0_l, b_req0_r} = b0_q[0]; else begin b_req0_l = $urandom; b_req0_r = $urandom; end
    b_req1_valid = (b1_q.size() > 0);
    if (b_req1_valid) {b_req1_l, b_req1_r} = b1_q[0]; else begin b_req1_l = $urandom; b_req1_r = $urandom; end
    @(negedge clk);

    // response monitor A
    while (exp_a_cyc_q.size() > 0 && exp_a_cyc_q[0] < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL a_missed_resp: expected at cycle %0d data %0d, got no response", exp_a_cyc_q[0], exp_a_q[0]);
      void'(exp_a_q.pop_front()); void'(exp_a_id_q.pop_front()); void'(exp_a_cyc_q.pop_front());
    end
    if (a_resp0_valid || a_resp1_valid) begin
      n_checks++;
      if (exp_a_q.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_resp: got v0=%0b v1=%0b at cycle %0d, required none", a_resp0_valid, a_resp1_valid, cyc);
      end else begin
        d = exp_a_q.pop_front(); id = exp_a_id_q.pop_front(); due = exp_a_cyc_q.pop_front();
        if ({a_resp1_valid, a_resp0_valid} !== (id ? 2'b10 : 2'b01) || due != cyc ||
            (id ? a_resp1_data : a_resp0_data) !== d) begin
          n_fail++;
          $display("FAIL a_resp: got v1v0=%b d0=%0d d1=%0d cyc=%0d, required id=%0d data=%0d cyc=%0d",
                   {a_resp1_valid, a_resp0_valid}, a_resp0_data, a_resp1_data, cyc, id, d, due);
        end
      end
    end
    // response monitor B
    while (exp_b_cyc_q.size() > 0 && exp_b_cyc_q[0] < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL b_missed_resp: expected at cycle %0d data %0d, got no response", exp_b_cyc_q[0], exp_b_q[0]);
      void'(exp_b_q.pop_front()); void'(exp_b_id_q.pop_front()); void'(exp_b_cyc_q.pop_front());
    end
    if (b_resp0_valid || b_resp1_valid) begin
      n_checks++;
      if (exp_b_q.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_resp: got v0=%0b v1=%0b at cycle %0d, required none", b_resp0_valid, b_resp1_valid, cyc);
      end else begin
        d = exp_b_q.pop_front(); id = exp_b_id_q.pop_front(); due = exp_b_cyc_q.pop_front();
        if ({b_resp1_valid, b_resp0_valid} !== (id ? 2'b10 : 2'b01) || due != cyc ||
            (id ? b_resp1_data : b_resp0_data) !== d) begin
          n_fail++;
          $display("FAIL b_resp: got v1v0=%b d0=%0d d1=%0d cyc=%0d, required id=%0d data=%0d cyc=%0d",
                   {b_resp1_valid, b_resp0_valid}, b_resp0_data, b_resp1_data, cyc, id, d, due);
        end
      end
    end
    // idle operand lines must be zero
    if (!a_unit_go) begin
      n_checks++;
      if ({a_unit_l, a_unit_r} !== '0) begin
        n_fail++; $display("FAIL a_idle_operands: got l=%0d r=%0d, required 0/0", a_unit_l, a_unit_r);
      end
    end
    if (!b_unit_go) begin
      n_checks++;
      if ({b_unit_l, b_unit_r} !== '0) begin
        n_fail++; $display("FAIL b_idle_operands: got l=%0d r=%0d, required 0/0", b_unit_l, b_unit_r);
      end
    end
    // transfers: push expected results from the bench's own operands
    if (a_req0_valid && a_req0_ready) begin
      exp_a_q.push_back(a0_q[0][2*W-1:W] + a0_q[0][W-1:0]); exp_a_id_q.push_back(1'b0);
      exp_a_cyc_q.push_back(cyc + LA + 1); grant_log_a.push_back(1'b0); void'(a0_q.pop_front());
    end
    if (a_req1_valid && a_req1_ready) begin
      exp_a_q.push_back(a1_q[0][2*W-1:W] + a1_q[0][W-1:0]); exp_a_id_q.push_back(1'b1);
      exp_a_cyc_q.push_back(cyc + LA + 1); grant_log_a.push_back(1'b1); void'(a1_q.pop_front());
    end
    if (b_req0_valid && b_req0_ready) begin
      exp_b_q.push_back(b0_q[0][2*W-1:W] + b0_q[0][W-1:0]); exp_b_id_q.push_back(1'b0);
      exp_b_cyc_q.push_back(cyc + LB + 1); void'(b0_q.pop_front());
    end
    if (b_req1_valid && b_req1_ready) begin
      exp_b_q.push_back(b1_q[0][2*W-1:W] + b1_q[0][W-1:0]); exp_b_id_q.push_back(1'b1);
      exp_b_cyc_q.push_back(cyc + LB + 1); void'(b1_q.pop_front());
    end
  endtask

  task automatic do_reset();
    a0_q.delete(); a1_q.delete(); b0_q.delete(); b1_q.delete();
    step(1'b0);
    step(1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a0_q.push_back({32'd1, 32'd2}); a1_q.push_back({32'd3, 32'd4});
    b0_q.push_back({32'd5, 32'd6}); b1_q.push_back({32'd7, 32'd8});
    step(1'b0);
    step(1'b0);
    n_checks++;
    if ({a_unit_go, a_req0_ready, a_req1_ready, a_busy, a_resp0_valid, a_resp1_valid} !== 6'b0 ||
        {a_resp0_data, a_resp1_data} !== '0) begin
      n_fail++; $display("FAIL reset_a: got go=%b rdy=%b%b busy=%b rv=%b%b d0=%0d d1=%0d, required all 0",
        a_unit_go, a_req0_ready, a_req1_ready, a_busy, a_resp0_valid, a_resp1_valid, a_resp0_data, a_resp1_data);
    end
    n_checks++;
    if ({b_unit_go, b_req0_ready, b_req1_ready, b_busy, b_resp0_valid, b_resp1_valid} !== 6'b0 ||
        {b_resp0_data, b_resp1_data} !== '0) begin
      n_fail++; $display("FAIL reset_b: got go=%b rdy=%b%b busy=%b rv=%b%b, required all 0",
        b_unit_go, b_req0_ready, b_req1_ready, b_busy, b_resp0_valid, b_resp1_valid);
    end
    a0_q.delete(); a1_q.delete(); b0_q.delete(); b1_q.delete();
  endtask

  task automatic test_single();
    int base;
    int k;
    do_reset();
    a0_q.push_back({32'd10, 32'd20});
    base = cyc + 1;
    for (int s = 0; s < 6; s++) begin
      step(1'b1);
      k = cyc - base;
      if (k == 0) begin
        n_checks++;
        if ({a_req0_ready, a_unit_go, a_unit_l, a_unit_r} !== {1'b1, 1'b1, 32'd10, 32'd20}) begin
          n_fail++; $display("FAIL single_issue: got rdy=%b go=%b l=%0d r=%0d, required 1 1 10 20",
                             a_req0_ready, a_unit_go, a_unit_l, a_unit_r);
        end
      end else begin
        n_checks++;
        if (a_unit_go !== 1'b0) begin n_fail++; $display("FAIL single_go_low: k=%0d got %b, required 0", k, a_unit_go); end
      end
      n_checks++;
      if (a_resp0_valid !== (k == 3)) begin
        n_fail++; $display("FAIL single_resp_pulse: k=%0d got %b, required %b", k, a_resp0_valid, (k == 3));
      end
      if (k == 3 || k == 5) begin
        n_checks++;
        if (a_resp0_data !== 32'd30) begin n_fail++; $display("FAIL single_resp_data: k=%0d got %0d, required 30", k, a_resp0_data); end
      end
      if (k == 3 || k == 4) begin
        n_checks++;
        if (a_busy !== (k == 3)) begin n_fail++; $display("FAIL single_busy: k=%0d got %b, required %b", k, a_busy, (k == 3)); end
      end
    end
  endtask

  task automatic test_simultaneous();
    int base;
    int k;
    do_reset();
    a0_q.push_back({32'd10, 32'd20});
    a1_q.push_back({32'd30, 32'd40});
    base = cyc + 1;
    for (int s = 0; s < 7; s++) begin
      step(1'b1);
      k = cyc - base;
      if (k == 0) begin
        n_checks++;
        if ({a_req0_ready, a_req1_ready, a_unit_go, a_unit_l, a_unit_r} !== {3'b101, 32'd10, 32'd20}) begin
          n_fail++; $display("FAIL simul_k0: got rdy0=%b rdy1=%b go=%b l=%0d r=%0d, required 1 0 1 10 20",
                             a_req0_ready, a_req1_ready, a_unit_go, a_unit_l, a_unit_r);
        end
      end
      if (k == 1) begin
        n_checks++;
        if ({a_req1_ready, a_unit_go} !== 2'b00) begin
          n_fail++; $display("FAIL simul_k1: got rdy1=%b go=%b, required 0 0", a_req1_ready, a_unit_go);
        end
      end
      if (k == 2) begin
        n_checks++;
        if ({a_req0_ready, a_req1_ready, a_unit_go, a_unit_l, a_unit_r} !== {3'b011, 32'd30, 32'd40}) begin
          n_fail++; $display("FAIL simul_k2: got rdy0=%b rdy1=%b go=%b l=%0d r=%0d, required 0 1 1 30 40",
                             a_req0_ready, a_req1_ready, a_unit_go, a_unit_l, a_unit_r);
        end
      end
      n_checks++;
      if ({a_resp0_valid, a_resp1_valid} !== {(k == 3), (k == 5)}) begin
        n_fail++; $display("FAIL simul_resp_timing: k=%0d got v0=%b v1=%b, required %b %b",
                           k, a_resp0_valid, a_resp1_valid, (k == 3), (k == 5));
      end
      if (k == 5) begin
        n_checks++;
        if ({a_resp0_data, a_resp1_data} !== {32'd30, 32'd70}) begin
          n_fail++; $display("FAIL simul_data: got d0=%0d d1=%0d, required 30 70", a_resp0_data, a_resp1_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int k;
    do_reset();
    for (int i = 1; i <= 3; i++) a0_q.push_back({W'(i), W'(i)});
    base = cyc + 1;
    for (int s = 0; s < 9; s++) begin
      step(1'b1);
      k = cyc - base;
      n_checks++;
      if (a_unit_go !== (k == 0 || k == 2 || k == 4)) begin
        n_fail++; $display("FAIL b2b_go: k=%0d got %b, required %b", k, a_unit_go, (k == 0 || k == 2 || k == 4));
      end
      n_checks++;
      if (a_resp0_valid !== (k == 3 || k == 5 || k == 7)) begin
        n_fail++; $display("FAIL b2b_resp: k=%0d got %b, required %b", k, a_resp0_valid, (k == 3 || k == 5 || k == 7));
      end
      if (k == 3 || k == 5 || k == 7) begin
        n_checks++;
        if (a_resp0_data !== W'(k - 1)) begin
          n_fail++; $display("FAIL b2b_data: k=%0d got %0d, required %0d", k, a_resp0_data, k - 1);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic exp_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    grant_log_a.delete();
    a0_q.push_back({32'd100, 32'd1}); a0_q.push_back({32'd100, 32'd2});
    a1_q.push_back({32'd200, 32'd3}); a1_q.push_back({32'd200, 32'd4});
    for (int s = 0; s < 11; s++) step(1'b1);
    n_checks++;
    if (grant_log_a.size() != 4) begin
      n_fail++; $display("FAIL fair_count: got %0d grants, required 4", grant_log_a.size());
    end
    for (int i = 0; i < 4 && i < grant_log_a.size(); i++) begin
      n_checks++;
      if (grant_log_a[i] !== exp_order[i]) begin
        n_fail++; $display("FAIL fair_order: grant %0d got id %0d, required %0d", i, grant_log_a[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int k;
    a0_q.push_back({32'd5, 32'd5});
    base = cyc + 1;
    for (int s = 0; s < 8; s++) begin
      if (s == 1) a0_q.push_back({32'd9, 32'd9});
      if (s == 3) a1_q.push_back({32'd7, 32'd8});
      step((s == 1) ? 1'b0 : 1'b1);
      k = cyc - base;
      if (k == 0) begin
        n_checks++;
        if (a_unit_go !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: got go=%b, required 1", a_unit_go); end
      end
      if (k == 1) begin
        n_checks++;
        if ({a_unit_go, a_req0_ready, a_req1_ready, a_busy, a_resp0_valid, a_resp1_valid} !== 6'b0 ||
            {a_resp0_data, a_resp1_data, a_unit_l, a_unit_r} !== '0) begin
          n_fail++; $display("FAIL rstmid_outputs: got go=%b rdy=%b%b busy=%b rv=%b%b d0=%0d d1=%0d, required all 0",
            a_unit_go, a_req0_ready, a_req1_ready, a_busy, a_resp0_valid, a_resp1_valid, a_resp0_data, a_resp1_data);
        end
        a0_q.delete();
      end
      if (k == 3) begin
        n_checks++;
        if ({a_req1_ready, a_unit_go, a_unit_l, a_unit_r} !== {2'b11, 32'd7, 32'd8}) begin
          n_fail++; $display("FAIL rstmid_reissue: got rdy1=%b go=%b l=%0d r=%0d, required 1 1 7 8",
                             a_req1_ready, a_unit_go, a_unit_l, a_unit_r);
        end
      end
      n_checks++;
      if ({a_resp0_valid, a_resp1_valid} !== {1'b0, (k == 6)}) begin
        n_fail++; $display("FAIL rstmid_resp: k=%0d got v0=%b v1=%b, required 0 %b", k, a_resp0_valid, a_resp1_valid, (k == 6));
      end
      if (k == 6) begin
        n_checks++;
        if (a_resp1_data !== 32'd15) begin n_fail++; $display("FAIL rstmid_data: got %0d, required 15", a_resp1_data); end
      end
    end
  endtask

  task automatic test_ii1();
    int base;
    int k;
    do_reset();
    base = cyc + 1;
    for (int s = 0; s < 9; s++) begin
      if (s < 6) begin
        if (s % 2 == 0) b0_q.push_back({W'(s), W'(10 * s)});
        else            b1_q.push_back({W'(s), W'(10 * s)});
      end
      step(1'b1);
      k = cyc - base;
      n_checks++;
      if (b_unit_go !== (k < 6)) begin
        n_fail++; $display("FAIL ii1_go: k=%0d got %b, required %b", k, b_unit_go, (k < 6));
      end
      n_checks++;
      if ({b_resp0_valid, b_resp1_valid} !== {(k >= 2 && k < 8 && k % 2 == 0), (k >= 2 && k < 8 && k % 2 == 1)}) begin
        n_fail++; $display("FAIL ii1_resp: k=%0d got v0=%b v1=%b", k, b_resp0_valid, b_resp1_valid);
      end
      if (k >= 2 && k < 8) begin
        n_checks++;
        if (((k % 2 == 0) ? b_resp0_data : b_resp1_data) !== W'(11 * (k - 2))) begin
          n_fail++; $display("FAIL ii1_data: k=%0d got d0=%0d d1=%0d, required %0d", k, b_resp0_data, b_resp1_data, 11 * (k - 2));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    a_req0_valid = 1'b0; a_req1_valid = 1'b0; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    a_req0_l = '0; a_req0_r = '0; a_req1_l = '0; a_req1_r = '0;
    b_req0_l = '0; b_req0_r = '0; b_req1_l = '0; b_req1_r = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_ii1();
    for (int s = 0; s < 4; s++) step(1'b1);
    n_checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d/%0d outstanding results, required 0/0", exp_a_q.size(), exp_b_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
